// File: rtl/rename_retirer_pkg.sv
// Shared sizing, FSM encodings and arch-register helpers for the rename retirement path.
package rename_retirer_pkg;

   localparam int PHYS_REGS = 32;
   localparam int PR_ADDR_W = 5;
   localparam int ROB_DEPTH = 8;
   localparam int ROB_TAG_W = 3;
   localparam int ARCH_REGS = 10;
   localparam int ARCH_W    = 4;

   localparam logic [0:0] RR_IDLE  = 1'b0;
   localparam logic [0:0] RR_FLUSH = 1'b1;

   localparam logic [ARCH_W-1:0] ARCH_NONE0 = 4'd0;
   localparam logic [ARCH_W-1:0] ARCH_NONE1 = 4'd1;

   // Arch 0/1 carry no rename, so their phys regs are never released.
   function automatic logic arch_renames(input logic [ARCH_W-1:0] arch);
      return (arch != ARCH_NONE0) && (arch != ARCH_NONE1);
   endfunction

   function automatic logic arch_in_table(input logic [ARCH_W-1:0] arch);
      return arch_renames(arch) && (arch < ARCH_W'(ARCH_REGS));
   endfunction

endpackage

// File: rtl/rename_retirer_phys_release_dec.sv
// Phys register + enable to one-hot free-pool mask; bit i stands for phys i+2.
module phys_release_dec
   import rename_retirer_pkg::*;
(
   input  logic                 en,
   input  logic [PR_ADDR_W-1:0] phys,
   output logic [PHYS_REGS-3:0] mask
);

   // Phys 0/1 are hardwired and have no bit in the mask
   always_comb begin
      mask = '0;
      if (en && (phys >= PR_ADDR_W'(2))) begin
         mask[phys - PR_ADDR_W'(2)] = 1'b1;
      end else begin
         mask = '0;
      end
   end

endmodule

// File: rtl/rename_retirer.sv
// In-order retirement queue for renamed micro-ops: commits aliases, frees superseded
// phys regs on retire, and unwinds fresh allocations youngest-first on flush.
module rename_retirer
   import rename_retirer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = ROB_TAG_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alloc_valid,
   output logic                           alloc_ready,
   input  logic [2*ARCH_W-1:0]            alloc_arch_regs,
   input  logic [2*PR_ADDR_W-1:0]         alloc_new_regs,
   input  logic [2*PR_ADDR_W-1:0]         alloc_old_regs,
   output logic [TAG_W-1:0]               alloc_tag,
   input  logic                           done_valid,
   input  logic [TAG_W-1:0]               done_tag,
   output logic [PHYS_REGS-3:0]           free_release,
   output logic                           commit_valid,
   output logic [PR_ADDR_W*ARCH_REGS-1:0] commit_aliases,
   input  logic                           flush,
   output logic                           flush_busy
);

   logic [0:0]             state_r;
   logic [TAG_W-1:0]       head_r;
   logic [TAG_W-1:0]       tail_r;
   logic [TAG_W:0]         count_r;
   logic [DEPTH-1:0]       valid_r;
   logic [DEPTH-1:0]       done_r;
   logic [2*ARCH_W-1:0]    arch_r [DEPTH];
   logic [2*PR_ADDR_W-1:0] new_r  [DEPTH];
   logic [2*PR_ADDR_W-1:0] old_r  [DEPTH];
   logic [PR_ADDR_W-1:0]   alias_r [ARCH_REGS];
   logic [PHYS_REGS-3:0]   free_r;
   logic                   commit_r;

   logic                   accept_s;
   logic                   retire_s;
   logic                   squash_s;
   logic                   flush_go_s;
   logic [TAG_W-1:0]       last_s;
   logic [2*ARCH_W-1:0]    sel_arch_s;
   logic [2*PR_ADDR_W-1:0] sel_phys_s;
   logic                   rel_en0_s;
   logic                   rel_en1_s;
   logic [PHYS_REGS-3:0]   mask0_s;
   logic [PHYS_REGS-3:0]   mask1_s;
   logic [ARCH_W-1:0]      head_arch0_s;
   logic [ARCH_W-1:0]      head_arch1_s;

   assign alloc_ready = (state_r == RR_IDLE) && (count_r < (TAG_W+1)'(DEPTH));
   assign alloc_tag   = tail_r;
   assign flush_busy  = (state_r == RR_FLUSH);
   assign last_s      = tail_r - TAG_W'(1);

   // Per-edge action select; a flush request pre-empts accept and retire
   always_comb begin
      accept_s   = 1'b0;
      retire_s   = 1'b0;
      squash_s   = 1'b0;
      flush_go_s = 1'b0;
      if (state_r == RR_IDLE) begin
         if (flush) begin
            flush_go_s = 1'b1;
         end else begin
            accept_s = alloc_valid && alloc_ready;
            retire_s = valid_r[head_r] && done_r[head_r];
         end
      end else begin
         squash_s = (count_r != '0);
      end
   end

   // Retire frees the superseded regs at head; squash frees the fresh regs at tail-1
   always_comb begin
      if (squash_s) begin
         sel_arch_s = arch_r[last_s];
         sel_phys_s = new_r[last_s];
      end else begin
         sel_arch_s = arch_r[head_r];
         sel_phys_s = old_r[head_r];
      end
   end

   assign rel_en0_s = (retire_s || squash_s) && arch_renames(sel_arch_s[ARCH_W-1:0]);
   assign rel_en1_s = (retire_s || squash_s) && arch_renames(sel_arch_s[2*ARCH_W-1:ARCH_W]);

   phys_release_dec u_rel0 (
      .en   (rel_en0_s),
      .phys (sel_phys_s[PR_ADDR_W-1:0]),
      .mask (mask0_s)
   );

   phys_release_dec u_rel1 (
      .en   (rel_en1_s),
      .phys (sel_phys_s[2*PR_ADDR_W-1:PR_ADDR_W]),
      .mask (mask1_s)
   );

   // FSM, queue pointers, occupancy and per-entry valid/done flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= RR_IDLE;
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         valid_r <= '0;
         done_r  <= '0;
      end else begin
         case (state_r)
            RR_IDLE: begin
               state_r <= flush_go_s ? RR_FLUSH : RR_IDLE;
               if (done_valid && valid_r[done_tag]) begin
                  done_r[done_tag] <= 1'b1;
               end
               if (retire_s) begin
                  valid_r[head_r] <= 1'b0;
                  done_r[head_r]  <= 1'b0;
                  head_r          <= head_r + TAG_W'(1);
               end
               if (accept_s) begin
                  valid_r[tail_r] <= 1'b1;
                  done_r[tail_r]  <= 1'b0;
                  tail_r          <= tail_r + TAG_W'(1);
               end
               case ({accept_s, retire_s})
                  2'b10:   count_r <= count_r + (TAG_W+1)'(1);
                  2'b01:   count_r <= count_r - (TAG_W+1)'(1);
                  default: count_r <= count_r;
               endcase
            end
            RR_FLUSH: begin
               if (squash_s) begin
                  valid_r[last_s] <= 1'b0;
                  done_r[last_s]  <= 1'b0;
                  tail_r          <= last_s;
                  count_r         <= count_r - (TAG_W+1)'(1);
                  state_r         <= (count_r == (TAG_W+1)'(1)) ? RR_IDLE : RR_FLUSH;
               end else begin
                  state_r <= RR_IDLE;
               end
            end
            default: begin
               state_r <= RR_IDLE;
            end
         endcase
      end
   end

   // Entry payload written on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            arch_r[i] <= '0;
            new_r[i]  <= '0;
            old_r[i]  <= '0;
         end
      end else if (accept_s) begin
         arch_r[tail_r] <= alloc_arch_regs;
         new_r[tail_r]  <= alloc_new_regs;
         old_r[tail_r]  <= alloc_old_regs;
      end
   end

   assign head_arch0_s = arch_r[head_r][ARCH_W-1:0];
   assign head_arch1_s = arch_r[head_r][2*ARCH_W-1:ARCH_W];

   // Committed alias table; slot1 is written last so it wins on a shared arch
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < ARCH_REGS; r++) begin
            alias_r[r] <= PR_ADDR_W'(r);
         end
      end else if (retire_s) begin
         if (arch_in_table(head_arch0_s)) begin
            alias_r[head_arch0_s] <= new_r[head_r][PR_ADDR_W-1:0];
         end
         if (arch_in_table(head_arch1_s)) begin
            alias_r[head_arch1_s] <= new_r[head_r][2*PR_ADDR_W-1:PR_ADDR_W];
         end
      end
   end

   // Registered one-cycle release and commit pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         free_r   <= '0;
         commit_r <= 1'b0;
      end else begin
         free_r   <= mask0_s | mask1_s;
         commit_r <= retire_s;
      end
   end

   assign free_release = free_r;
   assign commit_valid = commit_r;

   for (genvar g = 0; g < ARCH_REGS; g++) begin : g_alias
      assign commit_aliases[g*PR_ADDR_W +: PR_ADDR_W] = alias_r[g];
   end

endmodule

// File: tb/tb_rename_retirer.sv
// Randomized bench for rename_retirer against a queue-based reference model.
module tb_rename_retirer;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [7:0]  alloc_arch_regs;
   logic [9:0]  alloc_new_regs;
   logic [9:0]  alloc_old_regs;
   logic [2:0]  alloc_tag;
   logic        done_valid;
   logic [2:0]  done_tag;
   logic [29:0] free_release;
   logic        commit_valid;
   logic [49:0] commit_aliases;
   logic        flush;
   logic        flush_busy;

   rename_retirer dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_valid     (alloc_valid),
      .alloc_ready     (alloc_ready),
      .alloc_arch_regs (alloc_arch_regs),
      .alloc_new_regs  (alloc_new_regs),
      .alloc_old_regs  (alloc_old_regs),
      .alloc_tag       (alloc_tag),
      .done_valid      (done_valid),
      .done_tag        (done_tag),
      .free_release    (free_release),
      .commit_valid    (commit_valid),
      .commit_aliases  (commit_aliases),
      .flush           (flush),
      .flush_busy      (flush_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a0, a1;
      logic [4:0] n0, n1, o0, o1;
      logic [2:0] tag;
      bit         done;
   } ent_t;

   ent_t        q[$];
   int          m_tail;
   bit          m_fl;
   int          m_alias[10];
   logic [29:0] e_free;
   bit          e_cv;
   int          checks = 0;
   int          errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [29:0] rel(input logic [3:0] a, input logic [4:0] p);
      logic [29:0] m;
      m = '0;
      if (a >= 4'd2 && p >= 5'd2) m[p - 5'd2] = 1'b1;
      return m;
   endfunction

   function automatic logic [49:0] alias_vec();
      logic [49:0] v;
      for (int r = 0; r < 10; r++) v[r*5 +: 5] = m_alias[r][4:0];
      return v;
   endfunction

   // Apply one clock edge of the architectural rules to the model
   task automatic model_edge();
      ent_t e;
      bit   ret, acc;
      e_free = '0;
      e_cv   = 1'b0;
      if (rst) begin
         q.delete();
         m_tail = 0;
         m_fl   = 1'b0;
         for (int r = 0; r < 10; r++) m_alias[r] = r;
      end else if (m_fl) begin
         if (q.size() > 0) begin
            e      = q.pop_back();
            e_free = rel(e.a0, e.n0) | rel(e.a1, e.n1);
            m_tail = (m_tail + 7) % 8;
         end
         if (q.size() == 0) m_fl = 1'b0;
      end else if (flush) begin
         m_fl = 1'b1;
      end else begin
         ret = (q.size() > 0) && q[0].done;
         acc = alloc_valid && (q.size() < 8);
         if (done_valid) begin
            foreach (q[i]) if (q[i].tag == done_tag) q[i].done = 1'b1;
         end
         if (ret) begin
            e      = q.pop_front();
            e_cv   = 1'b1;
            e_free = rel(e.a0, e.o0) | rel(e.a1, e.o1);
            if (e.a0 >= 4'd2 && e.a0 < 4'd10) m_alias[e.a0] = e.n0;
            if (e.a1 >= 4'd2 && e.a1 < 4'd10) m_alias[e.a1] = e.n1;
         end
         if (acc) begin
            e.a0 = alloc_arch_regs[3:0];  e.a1 = alloc_arch_regs[7:4];
            e.n0 = alloc_new_regs[4:0];   e.n1 = alloc_new_regs[9:5];
            e.o0 = alloc_old_regs[4:0];   e.o1 = alloc_old_regs[9:5];
            e.tag  = m_tail[2:0];
            e.done = 1'b0;
            q.push_back(e);
            m_tail = (m_tail + 1) % 8;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("alloc_ready", alloc_ready, (!m_fl && q.size() < 8));
      check_eq("alloc_tag", alloc_tag, m_tail);
      check_eq("free_release", free_release, e_free);
      check_eq("commit_valid", commit_valid, e_cv);
      check_eq("commit_aliases", commit_aliases, alias_vec());
      check_eq("flush_busy", flush_busy, m_fl);
   endtask

   task automatic idle_inputs();
      alloc_valid = 1'b0; alloc_arch_regs = '0; alloc_new_regs = '0; alloc_old_regs = '0;
      done_valid = 1'b0; done_tag = '0; flush = 1'b0;
   endtask

   task automatic set_alloc(input logic [3:0] a1, input logic [3:0] a0, input logic [4:0] n1,
                            input logic [4:0] n0, input logic [4:0] o1, input logic [4:0] o0);
      alloc_valid = 1'b1;
      alloc_arch_regs = {a1, a0};
      alloc_new_regs  = {n1, n0};
      alloc_old_regs  = {o1, o0};
   endtask

   task automatic rand_alloc();
      set_alloc(4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)), 5'($urandom_range(31, 0)),
                5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1; step(); step();
      rst = 1'b0; step();
   endtask

   logic [49:0] rst_aliases;

   initial begin
      for (int r = 0; r < 10; r++) rst_aliases[r*5 +: 5] = 5'(r);
      idle_inputs();
      do_reset();
      check_eq("reset_aliases", commit_aliases, rst_aliases);
      check_eq("reset_ready", alloc_ready, 1'b1);
      check_eq("reset_free", free_release, 30'd0);

      // Basic retire: done in cycle k, pulses in cycle k+2
      set_alloc(4'd3, 4'd2, 5'd11, 5'd10, 5'd3, 5'd2); step();
      idle_inputs(); done_valid = 1'b1; done_tag = 3'd0; step();
      idle_inputs(); step();
      check_eq("basic_free", free_release, 30'h3);
      check_eq("basic_cv", commit_valid, 1'b1);
      check_eq("basic_alias2", commit_aliases[14:10], 5'd10);
      check_eq("basic_alias3", commit_aliases[19:15], 5'd11);

      // No-rename arch {1,0}
      set_alloc(4'd1, 4'd0, 5'd20, 5'd21, 5'd5, 5'd6); step();
      idle_inputs(); done_valid = 1'b1; done_tag = 3'd1; step();
      idle_inputs(); step();
      check_eq("norename_cv", commit_valid, 1'b1);
      check_eq("norename_free", free_release, 30'd0);

      // Fill to full, then out-of-order completion
      do_reset();
      for (int i = 0; i < 8; i++) begin rand_alloc(); step(); end
      check_eq("full_ready", alloc_ready, 1'b0);
      rand_alloc(); step();
      idle_inputs();
      done_valid = 1'b1;
      done_tag = 3'd3; step();
      done_tag = 3'd1; step();
      done_tag = 3'd0; step();
      done_tag = 3'd2; step();
      idle_inputs();
      for (int i = 0; i < 6; i++) step();

      // Flush unwinds youngest first
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_alloc(4'd0, 4'd2, 5'd0, 5'(12 + i), 5'd0, 5'd7); step();
      end
      idle_inputs(); flush = 1'b1; step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("flush_rel", free_release, 30'd1 << (12 - i));
         check_eq("flush_busy_seq", flush_busy, (i < 2));
      end
      check_eq("flush_ready", alloc_ready, 1'b1);
      check_eq("flush_tag", alloc_tag, 3'd0);

      // Reset mid-flush, then a done for an invalid tag
      for (int i = 0; i < 3; i++) begin rand_alloc(); step(); end
      idle_inputs(); flush = 1'b1; step();
      flush = 1'b0; step();
      rst = 1'b1; step();
      rst = 1'b0;
      check_eq("midflush_busy", flush_busy, 1'b0);
      check_eq("midflush_aliases", commit_aliases, rst_aliases);
      done_valid = 1'b1; done_tag = 3'd5; step();
      idle_inputs(); rand_alloc(); step();
      idle_inputs(); step(); step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         if ($urandom_range(99, 0) < 60) rand_alloc();
         if ($urandom_range(99, 0) < 50) begin
            done_valid = 1'b1;
            if (q.size() > 0 && $urandom_range(9, 0) < 7)
               done_tag = q[$urandom_range(q.size() - 1, 0)].tag;
            else
               done_tag = 3'($urandom_range(7, 0));
         end
         flush = ($urandom_range(99, 0) < 3);
         rst   = ($urandom_range(499, 0) == 0);
         step();
      end
      rst = 1'b0;
      idle_inputs();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
